// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store execution stage.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } lsu_state_e;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGNED = 2'd1,
        TIMEOUT    = 2'd2
    } lsu_err_e;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/lsu_timeout_counter.sv
// Bus-transaction watchdog: counts cycles spent in REQ/WAIT and flags the last permitted cycle.
module lsu_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("lsu_timeout_counter: TIMEOUT_CYCLES must be at least 2");
    end

    logic [CW-1:0] count_q, count_d;

    // Saturates on the last cycle so a stalled FSM can never wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == LAST);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle word load/store stage: address generation, data-memory handshake, writeback and error pulses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] immediate_i,
    input  logic [4:0]  rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        done_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o
);

    lsu_state_e  state_q, state_d;
    logic [31:2] addr_q, addr_d;
    logic [6:0]  opc_q, opc_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    lsu_err_e    cause_q, cause_d;

    logic [31:0] eff_addr;
    logic        accept;
    logic        is_store;
    logic        cnt_en;
    logic        expire;

    assign eff_addr = rs1_data_i + immediate_i;
    assign accept   = (state_q == IDLE) && valid_i && (is_load_i ^ is_store_i);
    assign is_store = (opc_q == OPC_STORE);
    assign cnt_en   = (state_q == REQ) || (state_q == WAIT);

    lsu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (accept),
        .enable_i(cnt_en),
        .expire_o(expire)
    );

    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        opc_d   = opc_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = eff_addr[31:2];
                    opc_d   = is_store_i ? OPC_STORE : OPC_LOAD;
                    wdata_d = rs2_data_i;
                    rd_d    = rd_i;
                    if (eff_addr[1:0] != 2'b00) begin
                        cause_d = MISALIGNED;
                        state_d = ERR;
                    end else begin
                        cause_d = NONE;
                        state_d = REQ;
                    end
                end
            end
            // A grant or rvalid on the expiry cycle still completes normally.
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = is_store ? DONE : WAIT;
                end else if (expire) begin
                    cause_d = TIMEOUT;
                    state_d = ERR;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = DONE;
                end else if (expire) begin
                    cause_d = TIMEOUT;
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    // NOTE: data latches are reset too, because they drive outputs with defined reset values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            opc_q   <= OPC_LOAD;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= '0;
            cause_q <= NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            opc_q   <= opc_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            cause_q <= cause_d;
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = mem_req_o && is_store;
    assign mem_addr_o  = {addr_q, 2'b00};
    assign mem_wdata_o = (mem_req_o && is_store) ? wdata_q : '0;
    assign done_o      = (state_q == DONE);
    assign wb_valid_o  = done_o && !is_store && (rd_q != 5'd0);
    assign wb_rd_o     = rd_q;
    assign wb_data_o   = rdata_q;
    assign err_o       = (state_q == ERR);
    assign err_cause_o = err_o ? cause_q : NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a memory responder and a completion scoreboard.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        is_load_i = 1'b0;
    logic        is_store_i = 1'b0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [31:0] immediate_i = '0;
    logic [4:0]  rd_i = '0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        done_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;
    logic [1:0]  err_cause_o;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .is_load_i   (is_load_i),
        .is_store_i  (is_store_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .immediate_i (immediate_i),
        .rd_i        (rd_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .done_o      (done_o),
        .wb_valid_o  (wb_valid_o),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o),
        .err_o       (err_o),
        .err_cause_o (err_cause_o)
    );

    // gnt_dly: REQ cycles before grant (-1 never); rv_dly: cycles from grant cycle to rvalid (-1 never).
    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [4:0]  rd;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        int          exp_lat;
        int          exp_req;
        logic        exp_err;
        logic [1:0]  exp_cause;
        logic        exp_wbv;
    } vec_t;

    typedef struct {
        logic        err;
        logic [1:0]  cause;
        logic        wbv;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni && (done_o || err_o)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'(done_o | err_o), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_err", 32'(err_o), 32'(mon_e.err));
                check("sb_done", 32'(done_o), 32'(!mon_e.err));
                check("sb_cause", 32'(err_cause_o), 32'(mon_e.cause));
                check("sb_wb_valid", 32'(wb_valid_o), 32'(mon_e.wbv));
                if (mon_e.wbv) begin
                    check("sb_wb_rd", 32'(wb_rd_o), 32'(mon_e.rd));
                    check("sb_wb_data", wb_data_o, mon_e.data);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int gk;
        int req_n;
        bit fin;
        gk = -1;
        req_n = 0;
        fin = 1'b0;
        @(negedge clk_i);
        check({v.name, "_ready_idle"}, 32'(ready_o), 32'd1);
        valid_i     = 1'b1;
        is_load_i   = v.ld;
        is_store_i  = v.st;
        rs1_data_i  = v.rs1;
        immediate_i = v.imm;
        rs2_data_i  = v.rs2;
        rd_i        = v.rd;
        sb_q.push_back(exp_t'{v.exp_err, v.exp_cause, v.exp_wbv, v.rd, v.rdata});
        for (int k = 1; k <= 30 && !fin; k++) begin
            @(negedge clk_i);
            valid_i      = 1'b0;
            is_load_i    = 1'b0;
            is_store_i   = 1'b0;
            rs1_data_i   = 32'h5555_5555;
            rs2_data_i   = 32'h6666_6666;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = ~v.rdata;
            check({v.name, "_ready_busy"}, 32'(ready_o), 32'd0);
            if (mem_req_o) begin
                req_n++;
                check({v.name, "_addr"}, mem_addr_o, v.exp_addr);
                check({v.name, "_we"}, 32'(mem_we_o), 32'(v.st));
                check({v.name, "_wdata"}, mem_wdata_o, v.st ? v.rs2 : 32'd0);
                if (v.gnt_dly >= 0 && req_n == v.gnt_dly + 1) begin
                    mem_gnt_i = 1'b1;
                    gk = k;
                end
            end else begin
                check({v.name, "_idle_we"}, 32'(mem_we_o), 32'd0);
                check({v.name, "_idle_wdata"}, mem_wdata_o, 32'd0);
            end
            if (gk >= 0 && v.rv_dly >= 0 && k == gk + v.rv_dly) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = v.rdata;
            end
            if (done_o || err_o) begin
                fin = 1'b1;
                check({v.name, "_latency"}, 32'(k), 32'(v.exp_lat));
                check({v.name, "_req_cycles"}, 32'(req_n), 32'(v.exp_req));
            end
        end
        if (!fin) check({v.name, "_no_completion"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //                name             ld    st    rs1           imm           rs2           rd  gnt rv  rdata         addr          lat req err cause wbv
        vecs.push_back(vec_t'{"ld_neg_imm",   1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h1111_1111, 5'd5,  0,  1, 32'hDEAD_BEEF, 32'h0000_0FFC, 3, 1, 1'b0, 2'd0, 1'b1});
        vecs.push_back(vec_t'{"st_gnt3",      1'b0, 1'b1, 32'h0000_0020, 32'h0000_0008, 32'hCAFE_0001, 5'd7,  3, -1, 32'h0000_0000, 32'h0000_0028, 5, 4, 1'b0, 2'd0, 1'b0});
        vecs.push_back(vec_t'{"ld_misal",     1'b1, 1'b0, 32'h0000_1001, 32'h0000_0000, 32'h2222_2222, 5'd3,  0, -1, 32'h0000_0000, 32'h0000_0000, 1, 0, 1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{"ld_tmo_wait",  1'b1, 1'b0, 32'h0000_0040, 32'h0000_0004, 32'h0,         5'd9,  0, -1, 32'h0000_0000, 32'h0000_0044, 5, 1, 1'b1, 2'd2, 1'b0});
        vecs.push_back(vec_t'{"ld_rv_expiry", 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 32'h0,         5'd10, 0,  3, 32'h1234_5678, 32'h0000_0080, 5, 1, 1'b0, 2'd0, 1'b1});
        vecs.push_back(vec_t'{"ld_rd0",       1'b1, 1'b0, 32'h0000_0100, 32'h0000_0010, 32'h0,         5'd0,  0,  1, 32'hA5A5_A5A5, 32'h0000_0110, 3, 1, 1'b0, 2'd0, 1'b0});
        vecs.push_back(vec_t'{"st_wrap",      1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0BAD_F00D, 5'd1,  0, -1, 32'h0000_0000, 32'h0000_0010, 2, 1, 1'b0, 2'd0, 1'b0});
        vecs.push_back(vec_t'{"st_tmo_nognt", 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0000, 32'h7777_0000, 5'd2, -1, -1, 32'h0000_0000, 32'h0000_0200, 5, 4, 1'b1, 2'd2, 1'b0});
        vecs.push_back(vec_t'{"st_misal",     1'b0, 1'b1, 32'h0000_0002, 32'h0000_0001, 32'h8888_0000, 5'd4,  0, -1, 32'h0000_0000, 32'h0000_0000, 1, 0, 1'b1, 2'd1, 1'b0});
        vecs.push_back(vec_t'{"ld_gnt_exp",   1'b1, 1'b0, 32'h0000_0001, 32'h0000_0003, 32'h0,         5'd31, 2,  1, 32'h0F0F_0F0F, 32'h0000_0004, 5, 3, 1'b0, 2'd0, 1'b1});
        vecs.push_back(vec_t'{"ld_rv_in_req", 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 32'h0,         5'd12, 2,  0, 32'h3C3C_3C3C, 32'h0000_0300, 5, 3, 1'b1, 2'd2, 1'b0});

        // Asynchronous reset: outputs must settle before any clock edge.
        #1 rst_ni = 1'b0;
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_ctrl", {26'd0, mem_req_o, mem_we_o, done_o, wb_valid_o, err_o, 1'b0}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_wb", {wb_rd_o, err_cause_o, 25'd0} | wb_data_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Illegal flag combinations must leave the unit idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            valid_i     = (i != 2);
            is_load_i   = (i != 1);
            is_store_i  = (i == 0);
            rs1_data_i  = 32'h0000_0400;
            immediate_i = 32'd0;
            @(negedge clk_i);
            valid_i    = 1'b0;
            is_load_i  = 1'b0;
            is_store_i = 1'b0;
            check($sformatf("ignore%0d_ready", i), 32'(ready_o), 32'd1);
            check($sformatf("ignore%0d_req", i), 32'(mem_req_o | done_o | err_o), 32'd0);
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during WAIT drops the transaction; a late rvalid must not complete anything.
        @(negedge clk_i);
        valid_i     = 1'b1;
        is_load_i   = 1'b1;
        rs1_data_i  = 32'h0000_0500;
        immediate_i = 32'd0;
        rd_i        = 5'd6;
        @(negedge clk_i);
        valid_i   = 1'b0;
        is_load_i = 1'b0;
        check("rstwait_req", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        check("rstwait_in_wait", {30'd0, ready_o, mem_req_o}, 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        check("rstwait_ready", 32'(ready_o), 32'd1);
        check("rstwait_outs", {wb_rd_o, 27'd0} | mem_addr_o, 32'd0);
        @(negedge clk_i);
        rst_ni       = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFEED_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            check($sformatf("late_rv%0d_done", i), 32'(done_o | wb_valid_o), 32'd0);
            check($sformatf("late_rv%0d_ready", i), 32'(ready_o), 32'd1);
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle word load/store execution stage sitting directly downstream of the load/store/shift decoder. Consumes the decoded `is_load`/`is_store` flags, the sign-extended immediate, `rd` and the register-file operands, and computes the effective address. It runs a request/grant/response transaction on the data-memory port and returns load data to the writeback stage. Misaligned accesses and memory timeouts are reported as one-cycle error pulses.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in REQ+WAIT before a bus error. Must be ≥2.
- `clk_i` input, 1 bit: single clock, rising edge.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `valid_i` input, 1 bit: upstream has a decoded instruction.
- `ready_o` output, 1 bit: unit idle and can accept.
- `is_load_i` input, 1 bit: decoded LW.
- `is_store_i` input, 1 bit: decoded SW.
- `rs1_data_i` input, 32 bits: base register value.
- `rs2_data_i` input, 32 bits: store data.
- `immediate_i` input, 32 bits: sign-extended offset.
- `rd_i` input, 5 bits: load destination register.
- `mem_req_o` output, 1 bit: memory request.
- `mem_we_o` output, 1 bit: 1 = write.
- `mem_addr_o` output, 32 bits: word address, byte-addressed, bits [1:0] always 0.
- `mem_wdata_o` output, 32 bits: write data.
- `mem_gnt_i` input, 1 bit: request accepted.
- `mem_rvalid_i` input, 1 bit: read data valid.
- `mem_rdata_i` input, 32 bits: read data.
- `done_o` output, 1 bit: one-cycle completion pulse.
- `wb_valid_o` output, 1 bit: write `wb_data_o` to `wb_rd_o`.
- `wb_rd_o` output, 5 bits: writeback register.
- `wb_data_o` output, 32 bits: loaded word.
- `err_o` output, 1 bit: one-cycle error pulse.
- `err_cause_o` output, 2 bits: 0 none, 1 misaligned, 2 timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: `ready_o`=1. A transaction is accepted when `valid_i` is high and exactly one of `is_load_i`/`is_store_i` is high. Any other combination is ignored, with no state change.
- On accept:
  - addr = `rs1_data_i` + `immediate_i`, computed modulo 2^32, with wrap-around allowed.
  - Latch addr, op, `rs2_data_i` and `rd_i`, and clear the timeout counter.
  - If addr[1:0] ≠ 0, go to ERR with cause 1; no memory request is issued.
  - Otherwise go to REQ.
- REQ: `mem_req_o`=1, with `mem_we_o`/`mem_addr_o`/`mem_wdata_o` held stable until grant.
  - On `mem_gnt_i`, a store goes to DONE and a load goes to WAIT.
  - `mem_rvalid_i` is ignored in REQ.
- WAIT: `mem_req_o`=0. On `mem_rvalid_i`, capture `mem_rdata_i` and go to DONE.
- Timeout counter:
  - Increments every cycle in REQ or WAIT.
  - When it equals `TIMEOUT_CYCLES`-1 and no grant/rvalid arrives that cycle, go to ERR with cause 2.
  - If grant/rvalid arrives in that same cycle, completion wins.
- DONE: `done_o`=1 for one cycle.
  - For a load, `wb_valid_o`=1 unless the latched rd = 0, in which case `wb_valid_o`=0 but `done_o` still pulses.
  - Then return to IDLE.
- ERR: `err_o`=1 and `err_cause_o` valid for one cycle, then IDLE.
- `mem_wdata_o` is 0 whenever `mem_req_o`=0 or the op is a load.
- Reset mid-operation: immediately returns to IDLE and drops any outstanding transaction. A late `mem_rvalid_i` arriving in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE; `ready_o`=1.
  - `mem_req_o`, `mem_we_o`, `done_o`, `wb_valid_o` and `err_o` are 0.
  - `mem_addr_o`, `mem_wdata_o`, `wb_rd_o`, `wb_data_o` and `err_cause_o` are 0.
- All outputs are decoded from registered state and latched data; no input-to-output combinational path.
- Store with same-cycle grant: accept c0, REQ c1, DONE c2.
  - Latency 2 cycles from accept to `done_o`.
- Load with same-cycle grant and next-cycle rvalid: accept c0, REQ c1, WAIT c2, DONE c3.
- Misaligned access: accept c0, ERR c1.
- `ready_o` is 0 from the cycle after accept until the unit returns to IDLE. Back-to-back accept is possible in the cycle after DONE or ERR.

## Structure
- Package `lsu_pkg`:
  - State enum `lsu_state_e`.
  - Error-cause enum `lsu_err_e` (NONE, MISALIGNED, TIMEOUT).
  - Opcode constants `OPC_LOAD`=7'b0000011 and `OPC_STORE`=7'b0100011.
- Sub-module `lsu_timeout_counter`:
  - Parameterised by `TIMEOUT_CYCLES`; width $clog2(`TIMEOUT_CYCLES`+1).
  - Inputs: clear, enable. Output: expire.
- Address adder, FSM and latches live in the top module.

## Test plan
- Load rs1=0x1000, imm=0xFFFFFFFC, rd=5, grant c1, rvalid c2 with rdata=0xDEADBEEF -> `mem_addr_o`=0x0FFC, `wb_valid_o`=1, `wb_rd_o`=5, `wb_data_o`=0xDEADBEEF, `done_o` at c3.
- Store rs1=0x20, imm=8, rs2=0xCAFE0001, grant delayed 3 cycles -> `mem_req_o` high 4 cycles with addr 0x28 and wdata stable, `mem_we_o`=1, `done_o` 1 cycle after grant, `wb_valid_o`=0.
- Load rs1=0x1001, imm=0 -> `err_o`=1, `err_cause_o`=1 at c1, `mem_req_o` never asserted.
- Load with grant but no rvalid, `TIMEOUT_CYCLES`=4 -> `err_cause_o`=2 four cycles after entering REQ; rvalid on the expiry cycle instead -> normal DONE.
- Load to rd=0, and `valid_i` with both flags set -> first gives `done_o`=1 with `wb_valid_o`=0; second is ignored with `ready_o` staying 1.
- `rst_ni` low during WAIT, then rvalid after release -> outputs return to reset values asynchronously; late rvalid produces no `done_o`.
